// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmitter: FSM states, parity and stop selections.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  localparam int DBITS_BASE = 5;

  // Keeps only the selected data bits of a byte (dbits=3 -> 8 bits, dbits=0 -> 5 bits).
  function automatic logic [7:0] data_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: pulses o_done on the tick that completes a period of i_last+1 ticks.
module uart_bit_timer #(
  parameter int OVS = 16,
  parameter int TW  = $clog2(2 * OVS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_s_tick,
  input  logic          i_clear,
  input  logic [TW-1:0] i_last,
  output logic          o_done
);

  logic [TW-1:0] cnt;

  // Terminal count is stored as ticks-1 so 2*OVS still fits in TW bits.
  assign o_done = i_s_tick && (cnt == i_last);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_s_tick) begin
      cnt <= o_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter, one frame per accepted byte, LSB first, format latched at acceptance.
// Define UART_TX_PARITY_EN to compile in the PARITY state and i_parity decoding.
module uart_tx_frame #(
  parameter int OVS = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_s_tick,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_din,
  input  logic [1:0] i_dbits,
  input  logic [1:0] i_parity,
  input  logic [1:0] i_stop,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_tx_done_tick
);
  import uart_pkg::*;

  localparam int TW = $clog2(2 * OVS);

  state_t        state, state_next;
  logic [7:0]    shreg, shreg_next;
  logic [2:0]    bitcnt, bitcnt_next;
  logic [1:0]    dbits_q, dbits_next;
  logic [1:0]    stop_q, stop_next;
  logic [2:0]    last_bit;
  logic [TW-1:0] last;
  logic          period_done;
  logic          timer_clear;
  logic          tx_next;
  logic          done_next;
`ifdef UART_TX_PARITY_EN
  logic          par_en_q, par_en_next;
  logic          par_bit_q, par_bit_next;
`else
  logic          unused_parity;
  assign unused_parity = ^(i_parity ^ PAR_NONE);
`endif

  assign o_ready     = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign last_bit    = 3'(DBITS_BASE - 1) + {1'b0, dbits_q};
  assign timer_clear = (state_next != state);

  always_comb begin
    last = TW'(OVS - 1);
    if (state == STOP) begin
      case (stop_q)
        STOP_1P5: last = TW'(3 * OVS / 2 - 1);
        STOP_2:   last = TW'(2 * OVS - 1);
        STOP_1:   last = TW'(OVS - 1);
        default:  last = TW'(OVS - 1);
      endcase
    end
  end

  uart_bit_timer #(.OVS(OVS), .TW(TW)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_s_tick (i_s_tick),
    .i_clear  (timer_clear),
    .i_last   (last),
    .o_done   (period_done)
  );

  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    bitcnt_next = bitcnt;
    dbits_next  = dbits_q;
    stop_next   = stop_q;
    done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next  = par_en_q;
    par_bit_next = par_bit_q;
`endif
    case (state)
      IDLE: begin
        if (i_valid) begin
          shreg_next  = i_din;
          bitcnt_next = '0;
          dbits_next  = i_dbits;
          stop_next   = i_stop;
`ifdef UART_TX_PARITY_EN
          par_en_next  = (i_parity == PAR_EVEN) || (i_parity == PAR_ODD);
          par_bit_next = (^(i_din & data_mask(i_dbits))) ^ (i_parity == PAR_ODD);
`endif
          state_next  = START;
        end
      end
      START: if (period_done) state_next = DATA;
      DATA: begin
        if (period_done) begin
          shreg_next  = {1'b0, shreg[7:1]};
          bitcnt_next = bitcnt + 3'd1;
          if (bitcnt == last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_next = par_en_q ? PARITY : STOP;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (period_done) state_next = STOP;
`endif
      STOP: begin
        if (period_done) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the next state so o_tx can be registered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_bit_q;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      shreg          <= '0;
      bitcnt         <= '0;
      dbits_q        <= '0;
      stop_q         <= '0;
      o_tx           <= 1'b1;
      o_tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      shreg          <= shreg_next;
      bitcnt         <= bitcnt_next;
      dbits_q        <= dbits_next;
      stop_q         <= stop_next;
      o_tx           <= tx_next;
      o_tx_done_tick <= done_next;
`ifdef UART_TX_PARITY_EN
      par_en_q       <= par_en_next;
      par_bit_q      <= par_bit_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frames queued at send time, checked tick by tick by a line monitor.
module tb_uart_tx_frame;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] dbits = 2'd0, par = 2'd0, stp = 2'd0;
  logic       ready, tx, busy, done;

  uart_tx_frame #(.OVS(OVS)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_s_tick       (s_tick),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_din          (din),
    .i_dbits        (dbits),
    .i_parity       (par),
    .i_stop         (stp),
    .o_tx           (tx),
    .o_busy         (busy),
    .o_tx_done_tick (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] dbits;
    logic [1:0] par;
    logic [1:0] stp;
    bit         b2b;
  } frame_t;

  frame_t q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cyc = -10;
  int done_cnt = 0;
  bit mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Baud tick every 4 clocks, driven just after the edge like all other inputs.
  initial begin : tick_gen
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      s_tick = (k % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit par_on(input logic [1:0] p);
    bit en;
    en = (p == 2'b01) || (p == 2'b10);
`ifndef UART_TX_PARITY_EN
    en = 1'b0;
`endif
    return en;
  endfunction

  function automatic logic exp_par(input frame_t e);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 5 + e.dbits; i++) x ^= e.data[i];
    return x ^ (e.par == 2'b10);
  endfunction

  function automatic int stop_ticks(input logic [1:0] s);
    case (s)
      2'b01:   return 3 * OVS / 2;
      2'b10:   return 2 * OVS;
      default: return OVS;
    endcase
  endfunction

  // Line monitor: every cycle of each segment must hold the expected level for its exact tick count.
  initial begin : mon
    frame_t e;
    logic   lvl[16];
    int     len[16];
    int     nseg, seg, n, w;
    bit     ok, aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      if (q.size() == 0) begin
        chk("unexpected_frame_tx", tx, 1);
        w = 0;
        while (busy === 1'b1 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        continue;
      end
      mon_busy = 1'b1;
      e = q.pop_front();
      if (e.b2b) chk("b2b_start_cycle", cyc, done_cyc + 1);
      lvl[0] = 1'b0;
      len[0] = OVS;
      nseg = 1;
      for (int i = 0; i < 5 + e.dbits; i++) begin
        lvl[nseg] = e.data[i];
        len[nseg] = OVS;
        nseg++;
      end
      if (par_on(e.par)) begin
        lvl[nseg] = exp_par(e);
        len[nseg] = OVS;
        nseg++;
      end
      lvl[nseg] = 1'b1;
      len[nseg] = stop_ticks(e.stp);
      nseg++;
      seg = 0;
      n = 0;
      ok = 1'b1;
      aborted = 1'b0;
      forever begin
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (tx !== lvl[seg]) ok = 1'b0;
        if (s_tick === 1'b1) begin
          n++;
          if (n == len[seg]) begin
            chk($sformatf("seg%0d_of_%0d_data%02h", seg, nseg, e.data), ok, 1);
            seg++;
            n = 0;
            ok = 1'b1;
            if (seg == nseg) break;
          end
        end
        @(negedge clk);
      end
      if (!aborted) begin
        @(negedge clk);
        chk($sformatf("done_pulse_data%02h", e.data), done, 1);
        chk($sformatf("ready_with_done_data%02h", e.data), ready, 1);
        done_cyc = cyc;
      end
      mon_busy = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] db, input logic [1:0] p,
                      input logic [1:0] s, input bit b2b, input bit hold);
    frame_t e;
    int n;
    din = d;
    dbits = db;
    par = p;
    stp = s;
    valid = 1'b1;
    e.data = d;
    e.dbits = db;
    e.par = p;
    e.stp = s;
    e.b2b = b2b;
    q.push_back(e);
    n = 0;
    while (ready !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) chk("send_timeout_ready", ready, 1);
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || mon_busy || ready !== 1'b1) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20000) chk("drain_timeout_queue", q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send(8'h55, 2'd3, 2'b00, 2'b00, 1'b0, 1'b0);  // 8N1
    drain();
    send(8'h07, 2'd3, 2'b01, 2'b00, 1'b0, 1'b0);  // 8E1
    drain();
    send(8'h7F, 2'd2, 2'b10, 2'b10, 1'b0, 1'b0);  // 7O2
    drain();
    send(8'hFF, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0);  // 5N1
    drain();
    send(8'h96, 2'd3, 2'b00, 2'b01, 1'b0, 1'b0);  // 8N1.5
    drain();

    send(8'hA5, 2'd3, 2'b00, 2'b00, 1'b0, 1'b1);
    send(8'h3C, 2'd3, 2'b00, 2'b00, 1'b1, 1'b0);
    drain();

    // Byte offered and format changed while a frame is in DATA.
    send(8'hC9, 2'd3, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (120) @(posedge clk);
    #1;
    chk("ready_low_while_busy", ready, 0);
    din = 8'h12;
    dbits = 2'd0;
    par = 2'b01;
    stp = 2'b10;
    valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of DATA.
    send(8'hC3, 2'd3, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (160) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, d0);
    chk("queue_empty_after_abort", q.size(), 0);

    send(8'h5A, 2'd3, 2'b00, 2'b00, 1'b0, 1'b0);
    drain();
    chk("total_done_pulses", done_cnt, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
